// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the serial sync-pattern link (transmitter and detector).
// Contents: state encoding, default 1101 sync pattern, default payload width,
// and a small width helper.
package seq_fsm_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned SYNC_W_DEF = 4;
  localparam logic [3:0]  SYNC_1101  = 4'b1101;

  // The 2-bit encoding is visible on the debug state port, so it is fixed explicitly.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SYNC = 2'b01,
    S_DATA = 2'b10,
    S_PAR  = 2'b11
  } seq_state_e;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_piso.sv
// Loadable parallel-in / serial-out shift register, MSB first.
// Ports: clk, reset (sync, active-low), load (capture pdata),
//        shift (shift left, zero fill), pdata (parallel word), sout (current MSB).
// Load has priority over shift.
module seq_piso #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] pdata,
  output logic         sout
);

  logic [W-1:0] r_sreg;

  // Zero fill means the register is empty once a whole frame has shifted out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sreg <= '0;
    end else if (load) begin
      r_sreg <= pdata;
    end else if (shift) begin
      r_sreg <= {r_sreg[W-2:0], 1'b0};
    end
  end

  assign sout = r_sreg[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: accepts a DATA_W-bit word over valid/ready and sends
// SYNC then the word, MSB first, one bit per clk on dout. Back-to-back frames
// with no idle bit are possible by accepting during the last bit.
// Ports: clk, reset (sync, active-low), din_valid/din/din_ready (input handshake),
//        dout (registered serial bit), frame_act (frame bit on dout),
//        last (final bit of the frame), state (FSM state for debug).
// Build option: define SEQ_TX_PARITY_EN to append one even-parity bit (^din).
module seq_frame_tx
  import seq_fsm_pkg::*;
#(
  parameter int unsigned        DATA_W = DATA_W_DEF,
  parameter int unsigned        SYNC_W = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0]  SYNC   = SYNC_W'(SYNC_1101)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              din_ready,
  output logic              dout,
  output logic              frame_act,
  output logic              last,
  output logic [1:0]        state
);

`ifdef SEQ_TX_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned FRM_W = SYNC_W + DATA_W + PAR_W;
  localparam int unsigned MAX_W = max_w(SYNC_W, DATA_W);
  localparam int unsigned CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  seq_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_frame_act;
  logic               r_last;

  logic               w_accept;
  logic               w_bad_state;
  logic               w_load;
  logic               w_shift;
  logic [FRM_W-1:0]   w_frame;
  logic [FRM_W-1:0]   w_pdata;
  logic               w_sout;

  // Whole frame is built at accept time, so later din changes cannot leak in.
`ifdef SEQ_TX_PARITY_EN
  assign w_frame     = {SYNC, din, ^din};
  assign w_bad_state = 1'b0;
`else
  assign w_frame     = {SYNC, din};
  assign w_bad_state = (r_state == S_PAR);
`endif

  assign din_ready = (r_state == S_IDLE) || r_last;
  assign w_accept  = din_valid && din_ready;

  // An illegal state also reloads zeros so dout is clean when falling back to IDLE.
  assign w_load  = w_accept || w_bad_state;
  assign w_pdata = w_accept ? w_frame : '0;
  assign w_shift = (r_state != S_IDLE);

  seq_piso #(.W(FRM_W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .pdata (w_pdata),
    .sout  (w_sout)
  );

  // Frame sequencer; last is registered one cycle ahead so it lines up with the final bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_frame_act <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_accept) begin
      r_state     <= S_SYNC;
      r_cnt       <= CNT_W'(SYNC_W - 1);
      r_frame_act <= 1'b1;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_frame_act <= 1'b0;
          r_last      <= 1'b0;
        end
        S_SYNC: begin
          if (r_cnt == '0) begin
            r_state <= S_DATA;
            r_cnt   <= CNT_W'(DATA_W - 1);
            r_last  <= (PAR_W == 0) && (DATA_W == 1);
          end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_last <= 1'b0;
          end
        end
        S_DATA: begin
          if (r_cnt == '0) begin
`ifdef SEQ_TX_PARITY_EN
            r_state <= S_PAR;
            r_last  <= 1'b1;
`else
            r_state     <= S_IDLE;
            r_frame_act <= 1'b0;
            r_last      <= 1'b0;
`endif
          end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_last <= (PAR_W == 0) && (r_cnt == CNT_W'(1));
          end
        end
`ifdef SEQ_TX_PARITY_EN
        S_PAR: begin
          r_state     <= S_IDLE;
          r_frame_act <= 1'b0;
          r_last      <= 1'b0;
        end
`endif
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_frame_act <= 1'b0;
          r_last      <= 1'b0;
        end
      endcase
    end
  end

  assign dout      = w_sout;
  assign frame_act = r_frame_act;
  assign last      = r_last;
  assign state     = r_state;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Randomized self-checking bench for seq_frame_tx against a bit-queue reference model.
module tb_seq_frame_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;
`ifdef SEQ_TX_PARITY_EN
  localparam int unsigned PW = 1;
`else
  localparam int unsigned PW = 0;
`endif
  localparam int unsigned L = SW + DW + PW;

  logic       clk = 1'b0;
  logic       reset;
  logic       din_valid;
  logic [7:0] din;
  logic       din_ready;
  logic       dout;
  logic       frame_act;
  logic       last;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  // Bits still to appear on dout; element 0 is the bit on dout this cycle.
  bit q[$];

  always #5 clk = ~clk;

  seq_frame_tx #(.DATA_W(DW), .SYNC_W(SW), .SYNC(4'b1101)) dut (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din       (din),
    .din_ready (din_ready),
    .dout      (dout),
    .frame_act (frame_act),
    .last      (last),
    .state     (state)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one rising edge to the model with the given inputs.
  task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
    bit         rdy;
    logic [3:0] sp;
    sp  = 4'b1101;
    rdy = (q.size() <= 1);
    if (!r) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (v && rdy) begin
        for (int i = SW - 1; i >= 0; i--) q.push_back(sp[i]);
        for (int i = DW - 1; i >= 0; i--) q.push_back(d[i]);
        if (PW == 1) q.push_back(^d);
      end
    end
  endtask

  function automatic logic [1:0] exp_state();
    int rem;
    rem = q.size();
    if (rem == 0)              return 2'b00;
    if (rem > int'(DW + PW))   return 2'b01;
    if (PW == 1 && rem == 1)   return 2'b11;
    return 2'b10;
  endfunction

  task automatic check_all();
    check_eq("dout",      8'(dout),      8'((q.size() > 0) ? q[0] : 1'b0));
    check_eq("frame_act", 8'(frame_act), 8'(q.size() > 0));
    check_eq("last",      8'(last),      8'(q.size() == 1));
    check_eq("din_ready", 8'(din_ready), 8'(q.size() <= 1));
    check_eq("state",     8'(state),     8'(exp_state()));
  endtask

  // Drive inputs for the next edge, advance the model, then check after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    din_valid = v;
    din       = d;
    reset     = r;
    model_edge(v, d, r);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [12:0] a5_tbl;
    logic [3:0]  win;
    int          act_cnt;
    int          det_cnt;

    a5_tbl    = 13'b1101_10100101_0;
    reset     = 1'b0;
    din_valid = 1'b1;
    din       = 8'hA5;
    @(negedge clk);

    // Reset held low with a valid word offered.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // Single A5 frame against the literal bit sequence.
    step(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < int'(L); i++) begin
      check_eq("a5_bit", 8'(dout), 8'(a5_tbl[12 - i]));
      step(1'b0, 8'($urandom), 1'b1);
    end
    step(1'b0, 8'h00, 1'b1);

    // Odd-weight word exercises the parity bit when enabled.
    step(1'b1, 8'h07, 1'b1);
    for (int i = 0; i < int'(L) + 2; i++) step(1'b0, 8'h00, 1'b1);

    // Back-to-back FF then 00 with valid held high.
    act_cnt = 0;
    det_cnt = 0;
    win     = 4'b0000;
    step(1'b1, 8'hFF, 1'b1);
    for (int c = 1; c <= int'(2 * L); c++) begin
      if (frame_act) act_cnt++;
      win = {win[2:0], dout};
      if (win == 4'b1101) det_cnt++;
      if (c < int'(L))       step(1'b1, 8'hFF, 1'b1);
      else if (c == int'(L)) step(1'b1, 8'h00, 1'b1);
      else                   step(1'b0, 8'h00, 1'b1);
    end
    check_eq("b2b_len", 8'(act_cnt), 8'(2 * L));
    check_eq("b2b_det", 8'(det_cnt), 8'd2);

    // Reset in cycle 6 of a frame aborts it.
    step(1'b1, 8'h3C, 1'b1);
    for (int c = 1; c < 6; c++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check_eq("abort_dout", 8'(dout), 8'd0);
    for (int i = 0; i < int'(L); i++) step(1'b0, 8'h00, 1'b1);

    // Valid pulses during a frame must be ignored.
    step(1'b1, 8'h5A, 1'b1);
    for (int c = 1; c < int'(L); c++) step(1'($urandom), 8'($urandom), 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom), 8'($urandom), 1'(($urandom % 150) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
